// File: rtl/glb_prr_stream_bridge_pkg.sv
// Shared sizing and per-channel config payload for the GLB <-> PRR stream bridge.
package glb_prr_stream_bridge_pkg;

  localparam int unsigned GLB_PRR_BRIDGE_NUM_CH  = 16;
  localparam int unsigned GLB_PRR_BRIDGE_COLS    = 2;
  localparam int unsigned GLB_PRR_BRIDGE_DATA_W  = 16;
  localparam int unsigned GLB_PRR_BRIDGE_MAX_DLY = 8;
  localparam int unsigned GLB_PRR_BRIDGE_IO_W    = 16;
  localparam int unsigned GLB_PRR_BRIDGE_CNT_W   = 16;
  localparam int unsigned GLB_PRR_BRIDGE_COL_W   = $clog2(GLB_PRR_BRIDGE_COLS);
  localparam int unsigned GLB_PRR_BRIDGE_DLY_W   = $clog2(GLB_PRR_BRIDGE_MAX_DLY);

  typedef struct packed {
    logic                              en;
    logic [GLB_PRR_BRIDGE_COL_W-1:0]   g2f_col;
    logic [GLB_PRR_BRIDGE_COL_W-1:0]   f2g_col;
    logic [GLB_PRR_BRIDGE_DLY_W-1:0]   f2g_dly;
  } glb_prr_bridge_cfg_t;

endpackage

// File: rtl/glb_prr_stream_bridge_ch.sv
// One GLB tile <-> PRR channel: config register, g2f column select, f2g delay line.
// Beat counter present only when GLB_PRR_BRIDGE_BEAT_CNT_EN is defined.
module glb_prr_bridge_ch
  import glb_prr_stream_bridge_pkg::*;
#(
  parameter int unsigned DATA_W = GLB_PRR_BRIDGE_DATA_W
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    cfg_wr,
  input  glb_prr_bridge_cfg_t                     cfg_in,
  input  logic [GLB_PRR_BRIDGE_COLS*DATA_W-1:0]   g2f_data,
  input  logic [GLB_PRR_BRIDGE_COLS-1:0]          g2f_valid,
  output logic [GLB_PRR_BRIDGE_IO_W-1:0]          io16,
  output logic                                    io1,
  input  logic [GLB_PRR_BRIDGE_IO_W-1:0]          c2g_io16,
  input  logic                                    c2g_io1,
  output logic [GLB_PRR_BRIDGE_COLS*DATA_W-1:0]   f2g_data,
  output logic [GLB_PRR_BRIDGE_COLS-1:0]          f2g_valid,
  output logic [GLB_PRR_BRIDGE_CNT_W-1:0]         beat_cnt
);

  localparam int unsigned COLS  = GLB_PRR_BRIDGE_COLS;
  localparam int unsigned COL_W = GLB_PRR_BRIDGE_COL_W;
  localparam int unsigned DEPTH = GLB_PRR_BRIDGE_MAX_DLY;
  localparam int unsigned IO_W  = GLB_PRR_BRIDGE_IO_W;
  localparam int unsigned CNT_W = GLB_PRR_BRIDGE_CNT_W;
  localparam int unsigned STG_W = DATA_W + 1;

  glb_prr_bridge_cfg_t      cfg_q;
  logic [STG_W-1:0]         stage [DEPTH];
  logic [STG_W-1:0]         stage_in;
  logic [STG_W-1:0]         tap;
  logic [DATA_W-1:0]        g2f_sel_data;
  logic                     g2f_sel_valid;
  logic [COLS*DATA_W-1:0]   f2g_data_nxt;
  logic [COLS-1:0]          f2g_valid_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       cfg_q <= '0;
    else if (cfg_wr) cfg_q <= cfg_in;
  end

  // g2f source column select
  always_comb begin
    g2f_sel_data  = '0;
    g2f_sel_valid = 1'b0;
    for (int unsigned c = 0; c < COLS; c++) begin
      if (cfg_q.g2f_col == COL_W'(c)) begin
        g2f_sel_data  = g2f_data[c*DATA_W +: DATA_W];
        g2f_sel_valid = g2f_valid[c];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io16 <= '0;
      io1  <= 1'b0;
    end else if (cfg_q.en) begin
      io16 <= IO_W'(g2f_sel_data);
      io1  <= g2f_sel_valid;
    end else begin
      io16 <= '0;
      io1  <= 1'b0;
    end
  end

  assign stage_in = cfg_q.en ? {c2g_io1, DATA_W'(c2g_io16)} : '0;
  assign tap      = stage[cfg_q.f2g_dly];

  // f2g delay line; a config write flushes it so no beat straddles two configs
  always_ff @(posedge clk or posedge reset) begin
    if (reset || cfg_wr) begin
      for (int unsigned k = 0; k < DEPTH; k++) stage[k] <= '0;
    end else begin
      stage[0] <= stage_in;
      for (int unsigned k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
    end
  end

  always_comb begin
    f2g_data_nxt  = '0;
    f2g_valid_nxt = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      if (cfg_q.f2g_col == COL_W'(c)) begin
        f2g_data_nxt[c*DATA_W +: DATA_W] = tap[DATA_W-1:0];
        f2g_valid_nxt[c]                 = tap[DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset || cfg_wr) begin
      f2g_data  <= '0;
      f2g_valid <= '0;
    end else begin
      f2g_data  <= f2g_data_nxt;
      f2g_valid <= f2g_valid_nxt;
    end
  end

`ifdef GLB_PRR_BRIDGE_BEAT_CNT_EN
  // Saturating count of valid beats handed to the GLB
  always_ff @(posedge clk or posedge reset) begin
    if (reset || cfg_wr) beat_cnt <= '0;
    else if ((|f2g_valid) && (beat_cnt != '1)) beat_cnt <= beat_cnt + CNT_W'(1);
  end
`else
  assign beat_cnt = '0;
`endif

endmodule

// File: rtl/glb_prr_stream_bridge.sv
// GLB strm_* <-> CGRA PRR io1/io16 bridge with per-channel programmable columns and f2g delay.
// Optional per-channel beat counters: define GLB_PRR_BRIDGE_BEAT_CNT_EN.
module glb_prr_stream_bridge
  import glb_prr_stream_bridge_pkg::*;
#(
  parameter int unsigned NUM_CH = GLB_PRR_BRIDGE_NUM_CH,
  parameter int unsigned DATA_W = GLB_PRR_BRIDGE_DATA_W
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           cfg_wr_en,
  input  logic [$clog2(NUM_CH)-1:0]                      cfg_ch,
  input  logic                                           cfg_en,
  input  logic [GLB_PRR_BRIDGE_COL_W-1:0]                cfg_g2f_col,
  input  logic [GLB_PRR_BRIDGE_COL_W-1:0]                cfg_f2g_col,
  input  logic [GLB_PRR_BRIDGE_DLY_W-1:0]                cfg_f2g_dly,
  input  logic [NUM_CH*GLB_PRR_BRIDGE_COLS*DATA_W-1:0]   strm_data_g2f,
  input  logic [NUM_CH*GLB_PRR_BRIDGE_COLS-1:0]          strm_data_valid_g2f,
  output logic [NUM_CH*GLB_PRR_BRIDGE_IO_W-1:0]          g2c_io16,
  output logic [NUM_CH-1:0]                              g2c_io1,
  input  logic [NUM_CH*GLB_PRR_BRIDGE_IO_W-1:0]          c2g_io16,
  input  logic [NUM_CH-1:0]                              c2g_io1,
  output logic [NUM_CH*GLB_PRR_BRIDGE_COLS*DATA_W-1:0]   strm_data_f2g,
  output logic [NUM_CH*GLB_PRR_BRIDGE_COLS-1:0]          strm_data_valid_f2g,
  output logic [NUM_CH*GLB_PRR_BRIDGE_CNT_W-1:0]         beat_cnt
);

  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned COLS  = GLB_PRR_BRIDGE_COLS;
  localparam int unsigned IO_W  = GLB_PRR_BRIDGE_IO_W;
  localparam int unsigned CNT_W = GLB_PRR_BRIDGE_CNT_W;

  glb_prr_bridge_cfg_t cfg_in;

  always_comb begin
    cfg_in         = '0;
    cfg_in.en      = cfg_en;
    cfg_in.g2f_col = cfg_g2f_col;
    cfg_in.f2g_col = cfg_f2g_col;
    cfg_in.f2g_dly = cfg_f2g_dly;
  end

  // Channel decode only matches existing channels, so out-of-range writes fall away
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_wr;
    assign ch_wr = cfg_wr_en && (cfg_ch == CH_W'(i));

    glb_prr_bridge_ch #(.DATA_W(DATA_W)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .cfg_wr    (ch_wr),
      .cfg_in    (cfg_in),
      .g2f_data  (strm_data_g2f[i*COLS*DATA_W +: COLS*DATA_W]),
      .g2f_valid (strm_data_valid_g2f[i*COLS +: COLS]),
      .io16      (g2c_io16[i*IO_W +: IO_W]),
      .io1       (g2c_io1[i]),
      .c2g_io16  (c2g_io16[i*IO_W +: IO_W]),
      .c2g_io1   (c2g_io1[i]),
      .f2g_data  (strm_data_f2g[i*COLS*DATA_W +: COLS*DATA_W]),
      .f2g_valid (strm_data_valid_f2g[i*COLS +: COLS]),
      .beat_cnt  (beat_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: doc/glb_prr_stream_bridge.md
Name: glb_prr_stream_bridge

Overview:
- Synthesizable bridge between global_buffer tile stream ports and the CGRA PRR IO ports; replaces the hard-wired, fixed-delay column mapping.
- Per channel (one GLB tile to one PRR), adds a programmable g2f source column, a programmable f2g destination column, a programmable f2g delay line, and a channel enable.
- Sits between global_buffer strm_* ports and cgra io1/io16 ports, inside the top-level integration.

Parameters:
- NUM_CH, 16, number of channels (NUM_GLB_TILES == NUM_PRR).
- COLS, 2, CGRA columns per GLB tile (CGRA_PER_GLB).
- DATA_W, 16, stream data width (CGRA_DATA_WIDTH).
- MAX_DLY, 8, f2g delay-line depth. Programmable delay range is 0..MAX_DLY-1.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- cfg_wr_en  in  1  config write strobe.
- cfg_ch  in  $clog2(NUM_CH)  channel being written.
- cfg_en  in  1  channel enable.
- cfg_g2f_col  in  $clog2(COLS)  g2f source column.
- cfg_f2g_col  in  $clog2(COLS)  f2g destination column.
- cfg_f2g_dly  in  $clog2(MAX_DLY)  extra f2g delay cycles.
- strm_data_g2f  in  NUM_CH*COLS*DATA_W  GLB-to-fabric data.
- strm_data_valid_g2f  in  NUM_CH*COLS  GLB-to-fabric valid.
- g2c_io16  out  NUM_CH*16  to PRR io16_g2io.
- g2c_io1  out  NUM_CH  to PRR io1_g2io.
- c2g_io16  in  NUM_CH*16  from PRR io16_io2g.
- c2g_io1  in  NUM_CH  from PRR io1_io2g.
- strm_data_f2g  out  NUM_CH*COLS*DATA_W  to GLB.
- strm_data_valid_f2g  out  NUM_CH*COLS  to GLB.
- beat_cnt  out  NUM_CH*16  f2g beat counters (see Optional Feature).

Behaviour:
- Reset (async assert, sync release):
  - All config registers = 0: channel disabled, both columns 0, delay 0.
  - All pipeline and delay stages cleared.
  - All outputs 0.
- Config:
  - On cfg_wr_en, channel cfg_ch's registers update on the next clk edge.
  - That channel's delay line and beat counter are cleared in the same edge.
  - Out-of-range cfg_ch (>= NUM_CH) is ignored.
- g2f path, per channel, fixed latency 1:
  - g2c_io16 and g2c_io1 are registered copies of column cfg_g2f_col.
  - Other columns are ignored.
  - Disabled channel registers 0 and 0.
- f2g path, per channel:
  - Shift register stage[0..MAX_DLY-1] of {valid, data}.
  - stage[0] <= {c2g_io1, c2g_io16}; stage[k] <= stage[k-1].
  - Output tap is stage[cfg_f2g_dly], registered once more, so total latency = cfg_f2g_dly + 2 cycles (delay 0 gives 2).
  - Tap lands on column cfg_f2g_col. All other columns drive valid = 0, data = 0.
  - Data is forwarded regardless of valid; data is don't-care when valid = 0 but stays deterministic.
- Disabled channel:
  - stage[0] captures 0 every cycle.
  - Outputs go to 0 once the line drains. Cfg writes clear the line immediately.
- Simultaneous cfg write and incoming f2g beat on the same channel: the write wins and the beat is dropped.
- Delay or column change mid-stream:
  - Beats already in the line are discarded by the clear.
  - The first new beat appears after the new latency.
- Reset mid-stream: all in-flight beats are lost and outputs drop to 0 asynchronously.
- Channels are fully independent. No cross-channel interaction.

Optional Feature:
- Macro: GLB_PRR_BRIDGE_BEAT_CNT_EN.
- Defined:
  - Per channel, a 16-bit counter increments on each cycle a valid f2g beat leaves on strm_data_valid_f2g.
  - Saturates at 16'hFFFF.
  - Cleared on reset and on a cfg write to that channel.
- Undefined: beat_cnt is tied to 0 and no counter flops are instantiated.

Decomposition:
- global_buffer_param package gains:
  - GLB_PRR_BRIDGE_MAX_DLY.
  - Typedef glb_prr_bridge_cfg_t {en, g2f_col, f2g_col, f2g_dly}.
- One sub-module, glb_prr_bridge_ch: single-channel config register, g2f register, delay line and counter. Instantiated NUM_CH times in a generate loop.

Test Plan:
- Reset, then write ch0 {en=1, g2f_col=0, f2g_col=1, dly=0}; drive c2g_io1[0]=1, c2g_io16[0]=16'hABCD for 1 cycle -> strm_data_valid_f2g[0][1]=1 with data 16'hABCD exactly 2 cycles later; column 0 stays 0.
- ch3 with dly=5 and a 4-beat burst 1,2,3,4 -> the same burst appears on the f2g_col column at 7-cycle latency, back-to-back, no gaps.
- ch2 {en=1, g2f_col=1}; drive column 1 with valid=1, data=16'h1234 and column 0 with data=16'hFFFF -> g2c_io16[2]=16'h1234, g2c_io1[2]=1 after 1 cycle.
- Stream into ch1 with dly=6, then rewrite ch1 to dly=1 mid-burst -> no stale beats emerge; new beats arrive at 3-cycle latency; the beat on the write cycle is dropped.
- Assert reset mid-burst on all channels -> all outputs 0 within the same timestep, before the next clk edge.
- With GLB_PRR_BRIDGE_BEAT_CNT_EN defined, drive 70000 valid beats on ch0 -> beat_cnt[0]=16'hFFFF. Rewrite ch0 -> beat_cnt[0]=0.
